// File: rtl/fpnew_pkg.sv
// Shared FP format definitions, classifier result type and FCLASS mask encoding.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned CLASS_MASK_BITS = 10;

  typedef enum logic [CLASS_MASK_BITS-1:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  // Unboxed operands read as the canonical quiet NaN; NaN classes ignore the sign.
  function automatic logic [CLASS_MASK_BITS-1:0] classify_to_mask(fp_info_t info, logic sign);
    if (!info.is_boxed)          return QNAN;
    else if (info.is_signalling) return SNAN;
    else if (info.is_quiet)      return QNAN;
    else if (info.is_inf)        return sign ? NEGINF     : POSINF;
    else if (info.is_normal)     return sign ? NEGNORM    : POSNORM;
    else if (info.is_subnormal)  return sign ? NEGSUBNORM : POSSUBNORM;
    else if (info.is_zero)       return sign ? NEGZERO    : POSZERO;
    else                         return '0;
  endfunction

endpackage

// File: rtl/fpnew_classifier.sv
// Shared operand classifier: decodes exponent/mantissa of each operand into fp_info_t.
module fpnew_classifier
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic     [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]            info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar op = 0; op < int'(NumOperands); op++) begin : g_op
    logic [EXP_BITS-1:0] exponent;
    logic [MAN_BITS-1:0] mantissa;
    logic                exp_max, exp_zero, man_zero, boxed;
    logic                unused_sign;

    assign exponent    = operands_i[op][WIDTH-2 -: EXP_BITS];
    assign mantissa    = operands_i[op][MAN_BITS-1:0];
    assign unused_sign = operands_i[op][WIDTH-1];
    assign boxed       = is_boxed_i[op];
    assign exp_max     = (exponent == '1);
    assign exp_zero    = (exponent == '0);
    assign man_zero    = (mantissa == '0);

    always_comb begin
      info_o[op]               = '0;
      info_o[op].is_boxed      = boxed;
      info_o[op].is_normal     = boxed && !exp_zero && !exp_max;
      info_o[op].is_zero       = boxed && exp_zero && man_zero;
      info_o[op].is_subnormal  = boxed && exp_zero && !man_zero;
      info_o[op].is_inf        = boxed && exp_max && man_zero;
      info_o[op].is_nan        = !boxed || (exp_max && !man_zero);
      info_o[op].is_signalling = boxed && exp_max && !man_zero && !mantissa[MAN_BITS-1];
      info_o[op].is_quiet      = info_o[op].is_nan && !info_o[op].is_signalling;
    end
  end

endmodule

// File: rtl/fpnew_fclass_unit.sv
// FCLASS unit: NaN-box check, classification, class-mask encoding and an
// elastic valid/ready pipeline of NumPipeRegs stages with flush.
module fpnew_fclass_unit
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned SrcWidth    = 64,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SrcWidth-1:0] operand_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [SrcWidth-1:0] result_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  localparam int unsigned WIDTH = fp_width(FpFormat);

  logic                       is_boxed;
  fp_info_t [0:0]             info;
  logic [CLASS_MASK_BITS-1:0] class_mask;

  if (SrcWidth == WIDTH) begin : g_box_full
    assign is_boxed = 1'b1;
  end else begin : g_box_check
    assign is_boxed = &operand_i[SrcWidth-1:WIDTH];
  end

  fpnew_classifier #(
    .FpFormat    (FpFormat),
    .NumOperands (1)
  ) i_classifier (
    .operands_i (operand_i[WIDTH-1:0]),
    .is_boxed_i (is_boxed),
    .info_o     (info)
  );

  assign class_mask = classify_to_mask(info[0], operand_i[WIDTH-1]);

  if (NumPipeRegs == 0) begin : g_comb
    logic unused_seq;
    assign unused_seq  = ^{clk_i, rst_ni, flush_i};
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign result_o    = SrcWidth'(class_mask);
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs-1:0] stage_valid;
    logic [NumPipeRegs-1:0] stage_ready;

    // Ready ripples backward from the output: a stage can take data if it is
    // empty or its own content is leaving this cycle.
    always_comb begin
      logic downstream_ready;
      stage_ready      = '0;
      downstream_ready = out_ready_i;
      for (int unsigned k = 0; k < NumPipeRegs; k++) begin
        downstream_ready = !stage_valid[NumPipeRegs-1-k] || downstream_ready;
        stage_ready[NumPipeRegs-1-k] = downstream_ready;
      end
    end

    for (genvar i = 0; i < int'(NumPipeRegs); i++) begin : g_stage
      logic                       up_valid;
      logic [CLASS_MASK_BITS-1:0] up_mask;
      logic [TagWidth-1:0]        up_tag;
      logic                       valid_q;
      logic [CLASS_MASK_BITS-1:0] mask_q;
      logic [TagWidth-1:0]        tag_q;
      logic                       load;

      if (i == 0) begin : g_src
        assign up_valid = in_valid_i;
        assign up_mask  = class_mask;
        assign up_tag   = tag_i;
      end else begin : g_src
        assign up_valid = g_stage[i-1].valid_q;
        assign up_mask  = g_stage[i-1].mask_q;
        assign up_tag   = g_stage[i-1].tag_q;
      end

      assign load           = up_valid && stage_ready[i];
      assign stage_valid[i] = valid_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             valid_q <= 1'b0;
        else if (flush_i)        valid_q <= 1'b0;
        else if (stage_ready[i]) valid_q <= up_valid;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mask_q <= '0;
          tag_q  <= '0;
        end else if (load) begin
          mask_q <= up_mask;
          tag_q  <= up_tag;
        end
      end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = g_stage[NumPipeRegs-1].valid_q;
    assign result_o    = SrcWidth'(g_stage[NumPipeRegs-1].mask_q);
    assign tag_o       = g_stage[NumPipeRegs-1].tag_q;
    assign busy_o      = |stage_valid;
  end

endmodule

// File: doc/fpnew_fclass_unit.md
Name: fpnew_fclass_unit

Overview:
Pipelined FCLASS execution unit for one FP format.
- Checks NaN-boxing of a FLEN-wide source operand and classifies it with the shared classifier.
- Encodes the classification into the 10-bit RISC-V class mask, zero-extended to FLEN.
- Sits in the NONCOMP operation group, downstream of operand distribution and upstream of the output arbiter.
- Uses valid/ready handshakes on both sides, has a configurable number of pipeline registers, and supports flush.

Parameters:
FpFormat, fpnew_pkg::FP32, format classified (WIDTH = fp_width(FpFormat))
SrcWidth, 64, operand/result width (FLEN); must be >= WIDTH
NumPipeRegs, 1, number of register stages between input and output (0 = combinational)
TagWidth, 4, width of the opaque tag carried alongside each operation

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  reset, asynchronous, active-low
operand_i  in  SrcWidth  source operand, format FpFormat in LSBs
tag_i  in  TagWidth  tag of the incoming operation
in_valid_i  in  1  input operation valid
in_ready_o  out  1  unit can accept an input this cycle
flush_i  in  1  synchronous kill of all in-flight operations
result_o  out  SrcWidth  class mask in bits [9:0], zeros above
tag_o  out  TagWidth  tag of the output operation
out_valid_o  out  1  output valid
out_ready_i  in  1  downstream accepts the output
busy_o  out  1  any operation in flight

Behaviour:
- Boxing: is_boxed = 1 if SrcWidth == WIDTH, else (operand_i[SrcWidth-1:WIDTH] == all ones).
- Classification: operand_i[WIDTH-1:0] and is_boxed feed one fpnew_classifier instance (NumOperands=1).
- Class mask (one-hot, computed combinationally before stage 0):
  - bit0 -inf; bit1 -normal; bit2 -subnormal; bit3 -zero
  - bit4 +zero; bit5 +subnormal; bit6 +normal; bit7 +inf
  - bit8 sNaN; bit9 qNaN
  - Sign is operand bit WIDTH-1.
  - NaN bits ignore the sign.
  - An unboxed input is a canonical qNaN: mask = 0x200.
- FCLASS raises no status flags.
- Pipeline, NumPipeRegs = N > 0: stages 0..N-1 each hold valid, mask and tag.
  - Stage k is ready when !valid_k || ready_{k+1}; ready_N = out_ready_i.
  - in_ready_o = ready_0.
  - A stage loads when its upstream is valid and the stage is ready.
  - A stage's valid clears when its content moves on and nothing new loads.
  - Latency is exactly N cycles with no backpressure.
  - Throughput is 1 operation per cycle with out_ready_i held high.
  - Simultaneous pop from the last stage and push into stage 0 in the same cycle is allowed.
- Output stability: while out_valid_o && !out_ready_i, result_o and tag_o hold stable and no data is lost.
- Pipeline, N = 0: fully combinational.
  - out_valid_o = in_valid_i; in_ready_o = out_ready_i.
  - result_o and tag_o are driven directly from the input.
  - busy_o = 0.
  - flush_i has no effect.
- Flush (N > 0): on an edge with flush_i = 1, all valid bits go to 0.
  - An input accepted in that same cycle is discarded.
  - in_ready_o is not gated by flush_i.
- Reset: asynchronous on rst_ni low.
  - All valid bits, mask registers and tag registers go to 0.
  - Therefore out_valid_o = 0, result_o = 0, tag_o = 0, busy_o = 0.
  - in_ready_o = 1 during and after reset.
  - Reset mid-operation drops all in-flight operations.
- busy_o = OR of all stage valid bits.
- Data registers load only on a stage load; no X propagation from an invalid input.

Decomposition:
- fpnew_pkg:
  - typedef classmask_e, 10-bit enum of the bit positions above
  - constant CLASS_MASK_BITS = 10
  - function classify_to_mask(fp_info_t, sign)
- Sub-modules: reuse the existing fpnew_classifier. The pipeline stage is a generate loop inside this module; no extra module is needed.

Test Plan:
Defaults for all scenarios: FP32, SrcWidth=64, N=1, out_ready_i=1.
1. 0xFFFFFFFF_3F800000 with tag 3 -> next cycle out_valid_o=1, result_o=0x40, tag_o=3.
2. Sign and zero/subnormal/inf cases:
   - 0xFFFFFFFF_FF800000 -> 0x001
   - 0xFFFFFFFF_80000000 -> 0x008
   - 0xFFFFFFFF_00000001 -> 0x020
   - 0xFFFFFFFF_807FFFFF -> 0x004
3. NaNs and boxing:
   - 0xFFFFFFFF_7F800001 -> 0x100
   - 0xFFFFFFFF_FFC00000 -> 0x200
   - unboxed 0x00000000_3F800000 -> 0x200
4. Backpressure: out_ready_i=0, send A (tag 1) then B (tag 2).
   - A holds stable at the output; in_ready_o=0 while B waits.
   - Raise out_ready_i -> A pops, B appears next cycle; nothing dropped or duplicated.
5. Flush: one op in flight plus flush_i=1 with a new input in the same cycle -> next cycle out_valid_o=0, busy_o=0; the new input never emerges.
6. Reset: rst_ni low asynchronously mid-stream -> outputs 0 immediately without a clock edge; after release in_ready_o=1 and a new op completes in 1 cycle.
   - Repeat with N=0 (combinational path) and N=3 (latency 3, back-to-back throughput 1/cycle).
